cp0: RTL and testbench

Coprocessor-0 block of the pipelined MIPS core: the receiving end of every device interrupt line (timer counters, external interrupt source) and of the pipeline's synchronous exception codes. Holds SR, Cause and EPC, decides each cycle whether the instruction at the macro-architectural commit point must be taken to the handler, and serves `mfc0`, `mtc0` and `eret`. Sits at the M stage; its request output flushes the pipeline and redirects fetch to the handler at 0x0000_4180.

---
 rtl/cp0.sv | 117 +++++++++++
 tb/tb_cp0.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC, interrupt and exception request, mfc0/mtc0/eret.
// Optional CP0_EPC_BYPASS_EN forwards an in-flight mtc0 $14 value onto EPCOut.
module cp0 (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   output logic [31:0] Dout,
   input  logic [4:0]  A2,
   input  logic [31:0] Din,
   input  logic        en,
   input  logic [31:0] VPC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic [31:0] EPCOut,
   output logic        Req
);

   localparam int unsigned IM_W  = 6;
   localparam int unsigned EXC_W = 5;
   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;

   logic [IM_W-1:0]  sr_im_q, sr_im_d;
   logic             sr_exl_q, sr_exl_d;
   logic             sr_ie_q, sr_ie_d;
   logic             cause_bd_q, cause_bd_d;
   logic [IM_W-1:0]  cause_ip_q, cause_ip_d;
   logic [EXC_W-1:0] cause_exc_q, cause_exc_d;
   logic [31:0]      epc_q, epc_d;

   logic        int_req;
   logic        exc_req;
   logic        wr_sr;
   logic        wr_epc;
   logic [31:0] exc_pc;
   logic [31:0] sr_val;
   logic [31:0] cause_val;

   assign int_req = (|(HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
   assign exc_req = (ExcCodeIn != 5'd0) & ~sr_exl_q;
   assign Req     = int_req | exc_req;
   assign wr_sr   = en & (A2 == REG_SR);
   assign wr_epc  = en & (A2 == REG_EPC);
   assign exc_pc  = BDIn ? (VPC - 32'd4) : VPC;

   assign sr_val    = {16'h0, sr_im_q, 8'h0, sr_exl_q, sr_ie_q};
   assign cause_val = {cause_bd_q, 15'h0, cause_ip_q, 3'h0, cause_exc_q, 2'b00};

   always_comb begin
      case (A1)
         REG_SR:    Dout = sr_val;
         REG_CAUSE: Dout = cause_val;
         REG_EPC:   Dout = epc_q;
         default:   Dout = 32'h0;
      endcase
   end

`ifdef CP0_EPC_BYPASS_EN
   assign EPCOut = wr_epc ? {Din[31:2], 2'b00} : epc_q;
`else
   assign EPCOut = epc_q;
`endif

   // Per-field priority: exception entry, then mtc0, then eret.
   always_comb begin
      sr_im_d     = sr_im_q;
      sr_exl_d    = sr_exl_q;
      sr_ie_d     = sr_ie_q;
      cause_bd_d  = cause_bd_q;
      cause_ip_d  = HWInt;
      cause_exc_d = cause_exc_q;
      epc_d       = epc_q;

      if (wr_sr) begin
         sr_im_d = Din[15:10];
         sr_ie_d = Din[0];
      end

      if (Req) begin
         sr_exl_d    = 1'b1;
         cause_exc_d = int_req ? 5'd0 : ExcCodeIn;
         cause_bd_d  = BDIn;
         epc_d       = {exc_pc[31:2], 2'b00};
      end else begin
         if (wr_sr)
            sr_exl_d = Din[1];
         else if (EXLClr)
            sr_exl_d = 1'b0;
         if (wr_epc)
            epc_d = {Din[31:2], 2'b00};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_im_q     <= '0;
         sr_exl_q    <= 1'b0;
         sr_ie_q     <= 1'b0;
         cause_bd_q  <= 1'b0;
         cause_ip_q  <= '0;
         cause_exc_q <= '0;
         epc_q       <= '0;
      end else begin
         sr_im_q     <= sr_im_d;
         sr_exl_q    <= sr_exl_d;
         sr_ie_q     <= sr_ie_d;
         cause_bd_q  <= cause_bd_d;
         cause_ip_q  <= cause_ip_d;
         cause_exc_q <= cause_exc_d;
         epc_q       <= epc_d;
      end
   end

endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: reset, interrupt/exception entry, priority, eret, mtc0.
module tb_cp0;

   logic        clk;
   logic        reset;
   logic [4:0]  A1;
   logic [31:0] Dout;
   logic [4:0]  A2;
   logic [31:0] Din;
   logic        en;
   logic [31:0] VPC;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic [31:0] EPCOut;
   logic        Req;

   int pass_cnt = 0;
   int total_cnt = 0;

   cp0 dut (
      .clk(clk), .reset(reset), .A1(A1), .Dout(Dout), .A2(A2), .Din(Din),
      .en(en), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
      .EXLClr(EXLClr), .EPCOut(EPCOut), .Req(Req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
      A1 = a;
      #1;
      chk(tag, Dout, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      en = 1'b1; A2 = a; Din = d;
      tick();
      en = 1'b0; A2 = 5'd0; Din = 32'h0;
   endtask

   initial begin
      reset = 1'b1; A1 = 5'd0; A2 = 5'd0; Din = 32'h0; en = 1'b0;
      VPC = 32'h0; BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'h0; EXLClr = 1'b0;
      #12;
      rd("rst_sr", 5'd12, 32'h0);
      rd("rst_cause", 5'd13, 32'h0);
      rd("rst_epc", 5'd14, 32'h0);
      chk("rst_epcout", EPCOut, 32'h0);
      chk("rst_req", 32'(Req), 32'h0);
      reset = 1'b0;
      tick();

      // Only IM/EXL/IE are writable in SR
      mtc0(5'd12, 32'hFFFF_FFFF);
      rd("sr_mask", 5'd12, 32'h0000_FC03);
      mtc0(5'd12, 32'h0000_FC01);
      rd("sr_fc01", 5'd12, 32'h0000_FC01);
      HWInt = 6'h01;
      #1;
      chk("req_pre_rst", 32'(Req), 32'h1);
      reset = 1'b1;
      #1;
      chk("midrst_req", 32'(Req), 32'h0);
      rd("midrst_sr", 5'd12, 32'h0);
      rd("midrst_cause", 5'd13, 32'h0);
      rd("midrst_epc", 5'd14, 32'h0);
      HWInt = 6'h00;
      tick();
      reset = 1'b0;
      tick();

      // Timer interrupt taken, not in delay slot
      mtc0(5'd12, 32'h0000_0401);
      HWInt = 6'h01; VPC = 32'h0000_3010; BDIn = 1'b0;
      #1;
      chk("int_req", 32'(Req), 32'h1);
      tick();
      chk("int_req_after", 32'(Req), 32'h0);
      chk("int_epcout", EPCOut, 32'h0000_3010);
      rd("int_cause", 5'd13, 32'h0000_0400);
      rd("int_sr", 5'd12, 32'h0000_0403);
      rd("int_epc", 5'd14, 32'h0000_3010);

      // Level interrupt re-requests after eret, here in a delay slot
      tick();
      chk("exl_hold_req", 32'(Req), 32'h0);
      EXLClr = 1'b1;
      #1;
      chk("exlclr_same_req", 32'(Req), 32'h0);
      tick();
      EXLClr = 1'b0; VPC = 32'h0000_3040; BDIn = 1'b1;
      #1;
      chk("reint_req", 32'(Req), 32'h1);
      tick();
      rd("reint_epc", 5'd14, 32'h0000_303C);
      rd("reint_cause", 5'd13, 32'h8000_0400);

      // Synchronous RI in a delay slot with SR=0
      HWInt = 6'h00; BDIn = 1'b0;
      mtc0(5'd12, 32'h0);
      rd("sr_zero", 5'd12, 32'h0);
      ExcCodeIn = 5'd10; VPC = 32'h0000_3024; BDIn = 1'b1;
      #1;
      chk("exc_req", 32'(Req), 32'h1);
      tick();
      ExcCodeIn = 5'd0; BDIn = 1'b0;
      rd("exc_epc", 5'd14, 32'h0000_3020);
      rd("exc_cause", 5'd13, 32'h8000_0028);
      rd("exc_sr", 5'd12, 32'h0000_0002);

      // Interrupt beats Ov; concurrent mtc0 EPC dropped
      mtc0(5'd12, 32'h0000_0401);
      HWInt = 6'h01; ExcCodeIn = 5'd12; VPC = 32'h0000_3050;
      en = 1'b1; A2 = 5'd14; Din = 32'h0000_1234;
      #1;
      chk("both_req", 32'(Req), 32'h1);
      tick();
      en = 1'b0; A2 = 5'd0; Din = 32'h0; ExcCodeIn = 5'd0; HWInt = 6'h00;
      rd("both_cause", 5'd13, 32'h0000_0400);
      rd("both_epc", 5'd14, 32'h0000_3050);

      // mtc0 $14 then eret
      en = 1'b1; A2 = 5'd14; Din = 32'h0000_3007;
      #1;
`ifdef CP0_EPC_BYPASS_EN
      chk("epc_bypass", EPCOut, 32'h0000_3004);
`else
      chk("epc_nobypass", EPCOut, 32'h0000_3050);
`endif
      tick();
      en = 1'b0; A2 = 5'd0; Din = 32'h0; EXLClr = 1'b1;
      #1;
      chk("eret_epcout", EPCOut, 32'h0000_3004);
      tick();
      EXLClr = 1'b0;
      rd("eret_sr", 5'd12, 32'h0000_0401);

      // Cause is not writable; unmapped register reads 0
      mtc0(5'd13, 32'hFFFF_FFFF);
      rd("cause_ro", 5'd13, 32'h0);
      rd("unmapped", 5'd15, 32'h0);

      // mtc0 SR beats eret on EXL
      en = 1'b1; A2 = 5'd12; Din = 32'h0000_0403; EXLClr = 1'b1;
      tick();
      en = 1'b0; A2 = 5'd0; Din = 32'h0; EXLClr = 1'b0;
      rd("mtc0_over_eret", 5'd12, 32'h0000_0403);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
